rv_byte_fifo: RTL and testbench
===============================

Name: rv_byte_fifo

Overview:
- Ready/valid byte FIFO between the serial capture stage (byte strobe, no backpressure) and the UART packetiser (ready/valid consumer).
- Absorbs bursts of bytes read back from the RF transceiver while the UART drains at line rate.
- Flags lost bytes and presents a registered first-word-fall-through output.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 16, total entries held, including the output register; power of 2, minimum 4.
- AF_THRESH, 12, level at which almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock (clk_wiz output domain).
- rst_n  in  1  asynchronous active-low reset.
- wr_data  in  WIDTH  byte from the serial capture stage.
- wr_valid  in  1  write strobe; the producer does not wait for wr_ready.
- wr_ready  out  1  high when level < DEPTH.
- rd_data  out  WIDTH  head byte; registered output.
- rd_valid  out  1  head byte present.
- rd_ready  in  1  consumer accepts the head byte.
- level  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- almost_full  out  1  high when level >= AF_THRESH.
- overflow  out  1  sticky flag for a dropped write.
- clr_ovf  in  1  synchronous clear of overflow (and drop_cnt).
- drop_cnt  out  16  count of dropped writes; see Optional Feature.

Behaviour:
- Reset (async assert, sync release): all outputs 0, except wr_ready, which is 1. rd_data is 0. Pointers are 0. Memory contents are don't-care.
- Write accept: wr_valid && wr_ready.
- Read accept: rd_valid && rd_ready.
- level update each cycle: level + write accept − read accept.
- Storage is a DEPTH−1 entry circular RAM plus one output register. Pointers are log2(DEPTH) bits and wrap modulo DEPTH−1 via compare-and-reset, not natural overflow.
- Write into an empty FIFO in cycle N: the byte loads the output register directly, and rd_valid=1 with rd_data=byte at cycle N+1. Latency is 1 cycle.
- rd_data and rd_valid must not change while rd_valid && !rd_ready.
- On a read accept with further entries in the RAM: the next byte is in the output register the following cycle. No bubble; sustained 1 byte/cycle is possible.
- On a read accept with the RAM empty:
  - With a simultaneous write accept, the written byte goes straight to the output register and rd_valid stays 1.
  - Otherwise rd_valid drops to 0.
- Simultaneous read and write at level=DEPTH: wr_ready is 0, so the write is not accepted. It counts as a drop even though a slot frees this cycle.
- Simultaneous write and read at 0 < level < DEPTH: level unchanged; ordering is preserved.
- Drop: wr_valid && !wr_ready sets overflow=1 on the next edge. overflow stays set until a clr_ovf cycle.
  - If clr_ovf and a drop occur in the same cycle, the set wins and overflow remains 1.
- wr_ready, almost_full and level are registered and consistent with each other every cycle.
- Reset asserted mid-transfer: contents are discarded immediately. Outputs return to reset values asynchronously; no partial byte is presented after release.
- Strict FIFO ordering with no duplication and no reordering.

Optional Feature:
- Macro RV_FIFO_DROP_CNT_EN.
- Defined: drop_cnt increments on every dropped write, saturates at 16'hFFFF, and is cleared by clr_ovf.
  - If clr_ovf coincides with a drop, drop_cnt becomes 1.
- Undefined: drop_cnt is tied to 16'h0000 and no counter logic is generated. overflow behaviour is unchanged.

Test Plan:
- Reset check: hold rst_n=0 with wr_valid=1 -> wr_ready=1, rd_valid=0, level=0, overflow=0 throughout. After release, no spurious output.
- Latency and ordering:
  - Stimulus: rd_ready=0; write 8'hA5 at cycle N, then 8'h3C.
  - Required: rd_valid=1 with rd_data=8'hA5 at N+1, level=2, and rd_data holds A5 while stalled.
  - Then rd_ready=1: read A5, then 3C on consecutive cycles.
- Fill and overflow:
  - Stimulus: with DEPTH=16 and rd_ready=0, write 8'h00..8'h11 (18 bytes).
  - Required: almost_full rises after the 12th accept, wr_ready=0 at level=16, overflow=1, drop_cnt=2 with the macro (0 without it).
  - Drain returns 00..0F in order.
- Full-with-read:
  - Stimulus: at level=16, pulse rd_ready and wr_valid together.
  - Required: write dropped, level=15, overflow set.
  - A write the next cycle is accepted, level=16.
- Streaming: rd_ready=1 with a write every cycle for 64 bytes 8'h40..8'h7F -> output matches at 1 byte/cycle, level never exceeds 1, no drops.
- Clear/drop collision: assert clr_ovf in the same cycle as a drop -> overflow stays 1 and drop_cnt=1; a later lone clr_ovf -> both 0.

Source files
------------

// File: rtl/rv_byte_fifo.sv
// rv_byte_fifo: ready/valid byte FIFO with a registered first-word-fall-through head and overflow tracking.
//
// A (DEPTH-1)-entry circular RAM feeds a single output register, so the
// total capacity is DEPTH. A write into an empty FIFO bypasses the RAM and
// lands in the output register, giving one cycle of write-to-read latency.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   wr_data     byte from the capture stage
//   wr_valid    write strobe (producer ignores wr_ready)
//   wr_ready    registered, high while level < DEPTH
//   rd_data     registered head byte
//   rd_valid    head byte present
//   rd_ready    consumer accepts the head byte
//   level       entries held, 0..DEPTH, output register included
//   almost_full registered, high while level >= AF_THRESH
//   overflow    sticky dropped-write flag, set wins over clr_ovf
//   clr_ovf     synchronous clear of overflow and drop_cnt
//   drop_cnt    saturating dropped-write count
//
// Build option: define RV_FIFO_DROP_CNT_EN to generate the drop counter;
// without it drop_cnt is tied to zero.
module rv_byte_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [15:0]            drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH-1];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic [LW-1:0]    r_level;
  logic             r_wr_ready;
  logic             r_af;
  logic             r_ovf;
  logic             w_wa;
  logic             w_ra;
  logic             w_drop;
  logic             w_ram_empty;
  logic             w_take;
  logic             w_load_ram;
  logic             w_load_wr;
  logic             w_ram_wr;
  logic [LW-1:0]    w_level_nxt;
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 2)) ? '0 : p + AW'(1);
  endfunction
  assign w_wa        = wr_valid & r_wr_ready;
  assign w_ra        = r_valid & rd_ready;
  assign w_drop      = wr_valid & ~r_wr_ready;
  // The RAM holds everything except the byte sitting in the output register.
  assign w_ram_empty = r_level == LW'(r_valid);
  // Output register may be refilled when it is empty or being consumed.
  assign w_take      = ~r_valid | w_ra;
  assign w_load_ram  = w_take & ~w_ram_empty;
  assign w_load_wr   = w_take & w_ram_empty & w_wa;
  assign w_ram_wr    = w_wa & ~w_load_wr;
  assign w_level_nxt = r_level + LW'(w_wa) - LW'(w_ra);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_level    <= '0;
      r_wr_ready <= 1'b1;
      r_af       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_ram_wr) r_wp <= ptr_inc(r_wp);
      if (w_load_ram) r_rp <= ptr_inc(r_rp);
      if (w_load_ram | w_load_wr) r_out <= w_load_ram ? r_mem[r_rp] : wr_data;
      if (w_take) r_valid <= w_load_ram | w_load_wr;
      r_level    <= w_level_nxt;
      r_wr_ready <= w_level_nxt < LW'(DEPTH);
      r_af       <= w_level_nxt >= LW'(AF_THRESH);
      r_ovf      <= w_drop | (r_ovf & ~clr_ovf);
    end
  end
  always_ff @(posedge clk) begin
    if (w_ram_wr) r_mem[r_wp] <= wr_data;
  end
`ifdef RV_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop_cnt <= '0;
    else if (clr_ovf) r_drop_cnt <= {15'd0, w_drop};
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'h0000;
`endif
  assign wr_ready    = r_wr_ready;
  assign rd_data     = r_out;
  assign rd_valid    = r_valid;
  assign level       = r_level;
  assign almost_full = r_af;
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_rv_byte_fifo.sv
// tb_rv_byte_fifo: queue-model checked bench for rv_byte_fifo with directed vectors.
module tb_rv_byte_fifo;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
`ifdef RV_FIFO_DROP_CNT_EN
  localparam logic [15:0] CNT1 = 16'd1;
  localparam logic [15:0] CNT2 = 16'd2;
`else
  localparam logic [15:0] CNT1 = 16'd0;
  localparam logic [15:0] CNT2 = 16'd0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic       clr_ovf = 1'b0;
  logic [15:0] drop_cnt;
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;

  rv_byte_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .level(level), .almost_full(almost_full),
    .overflow(overflow), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      bit wa, ra, drop;
      wa   = wr_valid && q.size() < DEPTH;
      drop = wr_valid && !wa;
      ra   = rd_ready && q.size() > 0;
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(wr_data);
      m_ovf = drop ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
`ifdef RV_FIFO_DROP_CNT_EN
      m_cnt = clr_ovf ? {15'd0, drop} : (drop && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
    end else begin
      chk("rd_valid", rd_valid, q.size() > 0);
      if (q.size() > 0) chk("rd_data", rd_data, q[0]);
      chk("level", level, q.size());
      chk("wr_ready", wr_ready, q.size() < DEPTH);
      chk("almost_full", almost_full, q.size() >= AF);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_cnt);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    repeat (3) cyc();
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    cyc();
    chk("post_rst_valid", rd_valid, 0);
    chk("post_rst_level", level, 0);
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    cyc();
    chk("lat_valid", rd_valid, 1);
    chk("lat_data", rd_data, 8'hA5);
    chk("lat_level", level, 1);
    wr_data = 8'h3C;
    cyc();
    wr_valid = 1'b0;
    chk("two_level", level, 2);
    chk("two_data", rd_data, 8'hA5);
    cyc();
    chk("stall_hold", rd_data, 8'hA5);
    rd_ready = 1'b1;
    cyc();
    chk("second_data", rd_data, 8'h3C);
    cyc();
    chk("drained_valid", rd_valid, 0);
    rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      cyc();
      if (i == 10) chk("af_below", almost_full, 0);
      if (i == 11) chk("af_at_12", almost_full, 1);
    end
    wr_valid = 1'b0;
    chk("full_level", level, 16);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_overflow", overflow, 1);
    chk("full_drop_cnt", drop_cnt, CNT2);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    cyc();
    rd_ready = 1'b0;
    wr_data  = 8'hEF;
    chk("fwr_level", level, 15);
    chk("fwr_overflow", overflow, 1);
    chk("fwr_drop_cnt", drop_cnt, CNT1);
    chk("fwr_head", rd_data, 8'h01);
    cyc();
    wr_valid = 1'b0;
    chk("refill_level", level, 16);
    rd_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("drain_order", rd_data, i);
      cyc();
    end
    chk("drain_tail", rd_data, 8'hEF);
    cyc();
    chk("drain_empty", rd_valid, 0);
    rd_ready = 1'b0;
    clr_ovf  = 1'b1;
    cyc();
    clr_ovf  = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h40 + i);
      cyc();
      chk("stream_data", rd_data, 8'h40 + i);
      chk("stream_level_le1", level <= 1, 1);
    end
    wr_valid = 1'b0;
    cyc();
    chk("stream_end_level", level, 0);
    chk("stream_no_drop", overflow, 0);
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h80 + i);
      cyc();
    end
    clr_ovf = 1'b1;
    cyc();
    clr_ovf  = 1'b0;
    wr_valid = 1'b0;
    chk("coll_overflow", overflow, 1);
    chk("coll_drop_cnt", drop_cnt, CNT1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("lone_clr_overflow", overflow, 0);
    chk("lone_clr_drop_cnt", drop_cnt, 0);
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    chk("async_level", level, 0);
    chk("async_valid", rd_valid, 0);
    chk("async_wr_ready", wr_ready, 1);
    chk("async_data", rd_data, 0);
    repeat (2) cyc();
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    cyc();
    chk("rel_valid", rd_valid, 0);
    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
